// File: rtl/dma_ch_pkg.sv
// dma_ch_pkg: register word map, CMD/STATUS bit positions and writable masks
// shared by the DMA channel register file and its command controller.
package dma_ch_pkg;

    // Word index = byte offset >> 2, decoded from paddr[5:2].
    typedef enum logic [3:0] {
        R_CMD          = 4'h0,
        R_STATUS       = 4'h1,
        R_CTRL         = 4'h2,
        R_XSIZE        = 4'h3,
        R_LINKADDR     = 4'h4,
        R_XADDRINC     = 4'h5,
        R_SRCTRIGINCFG = 4'h6,
        R_DESTRIGINCFG = 4'h7,
        R_TRIGOUTCFG   = 4'h8,
        R_SRCADDR      = 4'h9,
        R_DESADDR      = 4'hA,
        R_FILLVAL      = 4'hB
    } reg_idx_e;

    localparam logic [3:0] NUM_REGS = 4'd12;
    localparam int NUM_CFG = 10;

    localparam int CMD_ENABLE      = 0;
    localparam int CMD_DISABLE     = 2;
    localparam int CMD_STOP        = 3;
    localparam int CMD_PAUSE       = 4;
    localparam int CMD_RESUME      = 5;
    localparam int CMD_SRCSWREQ    = 16;
    localparam int CMD_SRCSWTYPE   = 17;
    localparam int CMD_DESSWREQ    = 20;
    localparam int CMD_DESSWTYPE   = 21;
    localparam int CMD_SWTRIGOUTACK = 24;

    localparam int STAT_DONE = 16;
    localparam int STAT_ERR  = 17;

    localparam logic [31:0] MASK_CTRL     = 32'h0E00_0E07;
    localparam logic [31:0] MASK_LINKADDR = 32'hFFFF_FFFD;
    localparam logic [31:0] MASK_TRIGIN   = 32'h0000_0FFF;
    localparam logic [31:0] MASK_TRIGOUT  = 32'h0000_033F;
    localparam logic [31:0] MASK_FULL     = 32'hFFFF_FFFF;

    function automatic logic [31:0] cfg_mask(logic [3:0] idx);
        return idx == R_CTRL ? MASK_CTRL :
               idx == R_LINKADDR ? MASK_LINKADDR :
               (idx == R_SRCTRIGINCFG || idx == R_DESTRIGINCFG) ? MASK_TRIGIN :
               idx == R_TRIGOUTCFG ? MASK_TRIGOUT : MASK_FULL;
    endfunction

endpackage

// File: rtl/dma_ch_cmd_ctrl.sv
// dma_ch_cmd_ctrl: CMD request/pulse bits cleared by engine events, and
// STATUS done/error flags with write-1-to-clear.
module dma_ch_cmd_ctrl
    import dma_ch_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_wr_i,
    input  logic        status_wr_i,
    input  logic [31:0] wdata_i,
    input  logic        done_evt_i,
    input  logic        err_evt_i,
    input  logic        stopped_evt_i,
    input  logic        src_trig_ack_i,
    input  logic        des_trig_ack_i,
    output logic [31:0] cmd_o,
    output logic [31:0] status_o
);

    logic [31:0] set;
    logic        enable_q, enable_d;
    logic [3:0]  pulse_q, pulse_d;
    logic        trigout_q, trigout_d;
    logic        src_req_q, src_req_d;
    logic [1:0]  src_type_q, src_type_d;
    logic        des_req_q, des_req_d;
    logic [1:0]  des_type_q, des_type_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        unused_wdata;

    assign unused_wdata = ^{wdata_i[31:25], wdata_i[23], wdata_i[19], wdata_i[15:6], wdata_i[1]};

    // A done_evt retires the old transfer, so a simultaneous ENABLECMD write survives;
    // err/stopped take priority over a new enable.
    always_comb begin
        set        = cmd_wr_i ? wdata_i : 32'h0;
        enable_d   = (enable_q & ~(done_evt_i | err_evt_i | stopped_evt_i))
                   | (set[CMD_ENABLE] & ~err_evt_i & ~stopped_evt_i);
        pulse_d    = set[CMD_RESUME:CMD_DISABLE];
        trigout_d  = set[CMD_SWTRIGOUTACK];
        src_req_d  = (src_req_q | set[CMD_SRCSWREQ]) & ~src_trig_ack_i;
        src_type_d = set[CMD_SRCSWREQ] ? wdata_i[CMD_SRCSWTYPE +: 2] : src_type_q;
        des_req_d  = (des_req_q | set[CMD_DESSWREQ]) & ~des_trig_ack_i;
        des_type_d = set[CMD_DESSWREQ] ? wdata_i[CMD_DESSWTYPE +: 2] : des_type_q;
        done_d     = done_evt_i | (done_q & ~(status_wr_i & wdata_i[STAT_DONE]));
        err_d      = err_evt_i | (err_q & ~(status_wr_i & wdata_i[STAT_ERR]));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            enable_q   <= 1'b0;
            pulse_q    <= 4'h0;
            trigout_q  <= 1'b0;
            src_req_q  <= 1'b0;
            src_type_q <= 2'b00;
            des_req_q  <= 1'b0;
            des_type_q <= 2'b00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            pulse_q    <= pulse_d;
            trigout_q  <= trigout_d;
            src_req_q  <= src_req_d;
            src_type_q <= src_type_d;
            des_req_q  <= des_req_d;
            des_type_q <= des_type_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        cmd_o                              = 32'h0;
        cmd_o[CMD_ENABLE]                  = enable_q;
        cmd_o[CMD_RESUME:CMD_DISABLE]      = pulse_q;
        cmd_o[CMD_SRCSWREQ]                = src_req_q;
        cmd_o[CMD_SRCSWTYPE +: 2]          = src_type_q;
        cmd_o[CMD_DESSWREQ]                = des_req_q;
        cmd_o[CMD_DESSWTYPE +: 2]          = des_type_q;
        cmd_o[CMD_SWTRIGOUTACK]            = trigout_q;
        status_o                           = 32'h0;
        status_o[STAT_DONE]                = done_q;
        status_o[STAT_ERR]                 = err_q;
    end

endmodule

// File: rtl/dma_ch_regfile.sv
// dma_ch_regfile: APB3 register file for one DMA channel; config registers are
// locked while the channel is enabled.
module dma_ch_regfile
    import dma_ch_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              done_evt,
    input  logic              err_evt,
    input  logic              stopped_evt,
    input  logic              src_trig_ack,
    input  logic              des_trig_ack,
    output logic [31:0]       CH_CMD,
    output logic [31:0]       CH_STATUS,
    output logic [31:0]       CH_CTRL,
    output logic [31:0]       CH_XSIZE,
    output logic [31:0]       CH_LINKADDR,
    output logic [31:0]       CH_XADDRINC,
    output logic [31:0]       CH_SRCTRIGINCFG,
    output logic [31:0]       CH_DESTRIGINCFG,
    output logic [31:0]       CH_TRIGOUTCFG,
    output logic [31:0]       CH_SRCADDR,
    output logic [31:0]       CH_DESADDR,
    output logic [31:0]       CH_FILLVAL
);

    logic [3:0]  idx;
    logic        bad;
    logic        setup_rd;
    logic        acc_wr;
    logic        cfg_we;
    logic [31:0] rd_data;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] cfg_q [NUM_CFG];
    logic [31:0] cfg_d [NUM_CFG];
    logic        unused_paddr;

    assign unused_paddr = ^{paddr[ADDR_W-1:6], paddr[1:0]};
    assign idx      = paddr[5:2];
    assign bad      = idx >= NUM_REGS;
    assign setup_rd = psel & ~penable & ~pwrite;
    assign acc_wr   = psel & penable & pwrite;
    assign cfg_we   = acc_wr & ~CH_CMD[CMD_ENABLE];

    dma_ch_cmd_ctrl u_cmd_ctrl (
        .clk            (clk),
        .resetn         (resetn),
        .cmd_wr_i       (acc_wr & (idx == R_CMD)),
        .status_wr_i    (acc_wr & (idx == R_STATUS)),
        .wdata_i        (pwdata),
        .done_evt_i     (done_evt),
        .err_evt_i      (err_evt),
        .stopped_evt_i  (stopped_evt),
        .src_trig_ack_i (src_trig_ack),
        .des_trig_ack_i (des_trig_ack),
        .cmd_o          (CH_CMD),
        .status_o       (CH_STATUS)
    );

    always_comb begin
        cfg_d = cfg_q;
        for (int i = 0; i < NUM_CFG; i++)
            if (cfg_we && idx == 4'(i + 2)) cfg_d[i] = pwdata & cfg_mask(4'(i + 2));
        rd_data   = idx == R_CMD ? CH_CMD :
                    idx == R_STATUS ? CH_STATUS :
                    bad ? 32'h0 : cfg_q[idx - 4'd2];
        prdata_d  = setup_rd ? rd_data : prdata_q;
        // Registered in setup so the error is visible throughout the access phase.
        pslverr_d = psel & ~penable & bad;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_q     <= '{default: '0};
            prdata_q  <= 32'h0;
            pslverr_q <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign prdata          = prdata_q;
    assign pslverr         = pslverr_q;
    assign pready          = 1'b1;
    assign CH_CTRL         = cfg_q[0];
    assign CH_XSIZE        = cfg_q[1];
    assign CH_LINKADDR     = cfg_q[2];
    assign CH_XADDRINC     = cfg_q[3];
    assign CH_SRCTRIGINCFG = cfg_q[4];
    assign CH_DESTRIGINCFG = cfg_q[5];
    assign CH_TRIGOUTCFG   = cfg_q[6];
    assign CH_SRCADDR      = cfg_q[7];
    assign CH_DESADDR      = cfg_q[8];
    assign CH_FILLVAL      = cfg_q[9];

endmodule

// File: tb/tb_dma_ch_regfile.sv
// tb_dma_ch_regfile: directed APB and engine-event vectors with hand-computed
// expectations for the DMA channel register file.
module tb_dma_ch_regfile;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = 12'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        done_evt = 1'b0, err_evt = 1'b0, stopped_evt = 1'b0;
    logic        src_trig_ack = 1'b0, des_trig_ack = 1'b0;
    logic [31:0] CH_CMD, CH_STATUS, CH_CTRL, CH_XSIZE, CH_LINKADDR, CH_XADDRINC;
    logic [31:0] CH_SRCTRIGINCFG, CH_DESTRIGINCFG, CH_TRIGOUTCFG, CH_SRCADDR, CH_DESADDR, CH_FILLVAL;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    logic        err;

    always #5 clk = ~clk;

    dma_ch_regfile #(.ADDR_W(12)) dut (
        .clk(clk), .resetn(resetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .done_evt(done_evt), .err_evt(err_evt), .stopped_evt(stopped_evt),
        .src_trig_ack(src_trig_ack), .des_trig_ack(des_trig_ack),
        .CH_CMD(CH_CMD), .CH_STATUS(CH_STATUS), .CH_CTRL(CH_CTRL), .CH_XSIZE(CH_XSIZE),
        .CH_LINKADDR(CH_LINKADDR), .CH_XADDRINC(CH_XADDRINC),
        .CH_SRCTRIGINCFG(CH_SRCTRIGINCFG), .CH_DESTRIGINCFG(CH_DESTRIGINCFG),
        .CH_TRIGOUTCFG(CH_TRIGOUTCFG), .CH_SRCADDR(CH_SRCADDR), .CH_DESADDR(CH_DESADDR),
        .CH_FILLVAL(CH_FILLVAL)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ev = {des_trig_ack, src_trig_ack, stopped_evt, err_evt, done_evt}, held during the access phase.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [4:0] ev,
                             output logic e);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        {des_trig_ack, src_trig_ack, stopped_evt, err_evt, done_evt} = ev;
        e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        {des_trig_ack, src_trig_ack, stopped_evt, err_evt, done_evt} = 5'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge clk); #1;
        d = prdata; e = pslverr;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) cycle();
        chk("rst_cmd", CH_CMD, 32'h0);
        chk("rst_status", CH_STATUS, 32'h0);
        chk("rst_ctrl", CH_CTRL, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("pready", 32'(pready), 32'h1);
        resetn = 1'b1;
        cycle();

        apb_write(12'h008, 32'hFFFF_FFFF, 5'b0, err);
        chk("ctrl_wr_err", 32'(err), 32'h0);
        apb_read(12'h008, rd, err);
        chk("ctrl_rd", rd, 32'h0E00_0E07);
        chk("ctrl_out", CH_CTRL, 32'h0E00_0E07);
        apb_write(12'h010, 32'hFFFF_FFFF, 5'b0, err);
        chk("linkaddr", CH_LINKADDR, 32'hFFFF_FFFD);
        apb_write(12'h020, 32'hFFFF_FFFF, 5'b0, err);
        chk("trigoutcfg", CH_TRIGOUTCFG, 32'h0000_033F);
        apb_write(12'h018, 32'hFFFF_FFFF, 5'b0, err);
        chk("srctrigincfg", CH_SRCTRIGINCFG, 32'h0000_0FFF);
        apb_write(12'h00C, 32'hDEAD_BEEF, 5'b0, err);
        apb_read(12'h00C, rd, err);
        chk("xsize_rd", rd, 32'hDEAD_BEEF);
        apb_write(12'h024, 32'hAAAA_5555, 5'b0, err);

        apb_write(12'h000, 32'h0000_0001, 5'b0, err);
        chk("enable_set", CH_CMD, 32'h0000_0001);
        apb_write(12'h024, 32'h0000_1234, 5'b0, err);
        chk("locked_err", 32'(err), 32'h0);
        chk("locked_srcaddr", CH_SRCADDR, 32'hAAAA_5555);
        done_evt = 1'b1;
        cycle();
        done_evt = 1'b0;
        chk("done_cmd", CH_CMD, 32'h0);
        chk("done_status", CH_STATUS, 32'h0001_0000);
        apb_write(12'h024, 32'h0000_1234, 5'b0, err);
        chk("unlocked_srcaddr", CH_SRCADDR, 32'h0000_1234);
        apb_write(12'h004, 32'h0001_0000, 5'b0, err);
        chk("w1c_done", CH_STATUS, 32'h0);

        apb_write(12'h000, 32'h0000_0010, 5'b0, err);
        chk("pause_pulse", CH_CMD, 32'h0000_0010);
        cycle();
        chk("pause_clear", CH_CMD, 32'h0);

        apb_write(12'h000, 32'h0005_0000, 5'b0, err);
        chk("srcreq_set", CH_CMD, 32'h0005_0000);
        repeat (3) cycle();
        chk("srcreq_hold", CH_CMD, 32'h0005_0000);
        src_trig_ack = 1'b1;
        chk("srcreq_at_ack", CH_CMD, 32'h0005_0000);
        cycle();
        src_trig_ack = 1'b0;
        chk("srcreq_clear", CH_CMD, 32'h0004_0000);

        apb_write(12'h000, 32'h0001_0000, 5'b01000, err);
        chk("ack_beats_write", CH_CMD & 32'h0001_0000, 32'h0);

        err_evt = 1'b1;
        cycle();
        err_evt = 1'b0;
        chk("err_set", CH_STATUS, 32'h0002_0000);
        apb_write(12'h004, 32'h0002_0000, 5'b00010, err);
        chk("err_beats_w1c", CH_STATUS, 32'h0002_0000);
        apb_write(12'h004, 32'h0002_0000, 5'b0, err);
        chk("w1c_err", CH_STATUS, 32'h0);

        apb_write(12'h000, 32'h0000_0001, 5'b0, err);
        apb_write(12'h000, 32'h0000_0001, 5'b00001, err);
        chk("reenable_cmd", CH_CMD & 32'h1, 32'h1);
        chk("reenable_status", CH_STATUS, 32'h0001_0000);

        apb_read(12'h008, rd, err);
        apb_read(12'h030, rd, err);
        chk("oor_rd_err", 32'(err), 32'h1);
        chk("oor_rd_data", rd, 32'h0);
        apb_write(12'h03C, 32'hFFFF_FFFF, 5'b0, err);
        chk("oor_wr_err", 32'(err), 32'h1);

        apb_write(12'h000, 32'h0001_0000, 5'b0, err);
        apb_read(12'h00C, rd, err);
        chk("pre_rst_cmd", CH_CMD, 32'h0001_0001);
        resetn = 1'b0;
        cycle();
        chk("mid_rst_cmd", CH_CMD, 32'h0);
        chk("mid_rst_status", CH_STATUS, 32'h0);
        chk("mid_rst_ctrl", CH_CTRL, 32'h0);
        chk("mid_rst_xsize", CH_XSIZE, 32'h0);
        chk("mid_rst_srcaddr", CH_SRCADDR, 32'h0);
        chk("mid_rst_prdata", prdata, 32'h0);
        chk("mid_rst_pslverr", 32'(pslverr), 32'h0);
        resetn = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
